recip_arbiter: RTL
==================

# recip_arbiter

Round-robin arbiter and sequencer that shares one fixed-point reciprocal unit between N requesters. It sits between the requesting blocks and the reciprocal unit. It accepts one request at a time, issues a single-cycle start pulse, and holds the operand stable until the unit reports done. It then returns the Q-format result to the granted requester. An optional watchdog aborts a hung operation and latches a sticky fault.

## Interface
- N, 4: number of requesters (2..8)
- W, 32: operand/result width (Q(W-F).F, signed operand)
- TIMEOUT, 32: maximum WAIT cycles before abort (watchdog builds only, ≥ 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N  per-requester request
- req_x  in  N*W  operands; requester i at bits [i*W +: W]
- req_ready  out  N  one-hot accept strobe; a request is taken when req_valid[i] && req_ready[i]
- rsp_valid  out  N  one-hot, one-cycle response pulse to the granted requester
- rsp_data  out  W  result, valid while any rsp_valid bit is high
- rsp_invalid  out  1  unit flagged operand ≤ 0, valid with rsp_valid
- rsp_err  out  1  watchdog abort, valid with rsp_valid
- busy  out  1  high in every state except IDLE
- fault  out  1  sticky watchdog fault
- recip_start  out  1  one-cycle start to the unit
- recip_x  out  W  operand to the unit
- recip_done  in  1  unit done (one-cycle pulse)
- recip_y  in  W  unit result, sampled with done
- recip_invalid  in  1  unit invalid flag, sampled with done

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If fault=0 and any req_valid is high, the grant goes to the first valid index searching upward from last+1 (mod N).
  - req_ready[grant]=1 combinationally in this cycle.
  - The operand is registered into recip_x and the grant index is registered. Next state is ISSUE.
- **ISSUE**: recip_start=1 for exactly this cycle. The watchdog counter is cleared. Next state is WAIT.
- **WAIT**
  - recip_done is only observed in this state.
  - On recip_done: register recip_y into rsp_data, recip_invalid into rsp_invalid, and set rsp_err=0. Next state is RESP.
- **RESP**
  - rsp_valid[grant]=1 for one cycle.
  - last ← grant. Next state is IDLE.
- The requester has no backpressure and must consume the response in that cycle.
- recip_x changes only on an IDLE accept. It is stable from ISSUE through RESP, regardless of req_x.
- recip_done seen in IDLE, ISSUE or RESP is ignored.
- The reset value of `last` is N-1, so requester 0 has first priority after reset.
- While fault=1, req_ready stays 0 and no requests are accepted.

## Timing
- Reset (asynchronous) clears the following:
  - State goes to IDLE and last goes to N-1.
  - recip_x, rsp_data, the grant index and the watchdog counter go to 0.
  - Every output goes to 0: req_ready, rsp_valid, rsp_invalid, rsp_err, busy, fault and recip_start.
- Reset mid-operation: the in-flight request is dropped with no response. The unit shares rst_n.
- Latency for an accept in cycle 0:
  - recip_start is high in cycle 1.
  - If recip_done arrives in cycle 1+D (D ≥ 1), rsp_valid is high in cycle 2+D.
  - The next accept is possible in cycle 3+D.
- Throughput is one operation in flight at a time.
- A request held while not granted keeps req_valid high. Withdrawing it is allowed before acceptance.

## Configuration
- **RECIP_ARB_TIMEOUT_EN defined**
  - Counter width is $clog2(TIMEOUT+1). It increments each WAIT cycle without recip_done.
  - If the counter equals TIMEOUT-1 and done is absent, the block enters RESP with rsp_data=0, rsp_invalid=0, rsp_err=1, and sets fault=1.
  - If done arrives in that same cycle, done wins and there is no fault.
  - fault clears only on reset.
- **Not defined**
  - WAIT persists until recip_done.
  - No counter is present. rsp_err and fault are tied to 0.

## Test plan
- **Single request.** Stimulus: req_valid[1]=1, req_x[1]=0x00020000; model asserts done 9 cycles after start with y=0x00008000. Required: req_ready[1] high in cycle 0, recip_start high only in cycle 1, rsp_valid=4'b0010 in cycle 11, rsp_data=0x00008000, rsp_invalid=0.
- **Round-robin.** Stimulus: all four requesters valid continuously from reset. Required: grants in order 0,1,2,3. Then with only requesters 0 and 2 valid, grants continue 0,2,0.
- **Invalid operand.** Stimulus: req_x=0xFFFF0000; model returns done with invalid=1, y=0. Required: rsp_invalid=1, rsp_data=0, rsp_err=0.
- **Operand hold.** Stimulus: req_x changes every cycle after accept. Required: recip_x stays equal to the accepted value from cycle 1 through RESP.
- **Watchdog** (RECIP_ARB_TIMEOUT_EN, TIMEOUT=32). Stimulus: model never asserts done. Required:
  - rsp_valid pulses 33 cycles after start, with rsp_err=1 and rsp_data=0.
  - fault=1 and req_ready stays 0.
  - A late recip_done is ignored.
  - rst_n clears fault.
- **Reset in WAIT.** Stimulus: rst_n low 3 cycles after start. Required: all outputs 0 immediately and no rsp_valid afterward; the next request is granted normally.

Source files
------------

// File: rtl/recip_arbiter.sv
// Round-robin sequencer sharing one fixed-point reciprocal unit among N requesters.
// Define RECIP_ARB_TIMEOUT_EN to build the WAIT-state watchdog with its sticky fault.
module recip_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_x,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_invalid,
  output logic           rsp_err,
  output logic           busy,
  output logic           fault,
  output logic           recip_start,
  output logic [W-1:0]   recip_x,
  input  logic           recip_done,
  input  logic [W-1:0]   recip_y,
  input  logic           recip_invalid
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_grant;
  logic [W-1:0]  r_recipX;
  logic [W-1:0]  r_rspData;
  logic [N-1:0]  r_rspValid;
  logic          r_rspInvalid;
  logic          r_busy;
  logic          r_start;

  logic          w_found;
  logic [IW-1:0] w_grantIdx;
  logic [IW:0]   w_sum;
  logic          w_accept;
  logic [N-1:0]  w_reqReady;
  logic [W-1:0]  w_operand;

  generate
    if (N < 2 || N > 8 || TIMEOUT < 2) begin : g_paramCheck
      $error("recip_arbiter: N must be 2..8 and TIMEOUT at least 2");
    end
  endgenerate

  // Search upward from last+1, wrapping modulo N, for the first valid requester.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = '0;
    w_sum      = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, r_last} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      if (!w_found && req_valid[w_sum[IW-1:0]]) begin
        w_found    = 1'b1;
        w_grantIdx = w_sum[IW-1:0];
      end
    end
  end

  // rst_n gates the combinational accept so req_ready reads 0 during reset.
  assign w_accept  = rst_n && (r_state == S_IDLE) && !fault && w_found;
  assign w_operand = req_x[w_grantIdx*W +: W];

  always_comb begin
    w_reqReady = '0;
    if (w_accept) w_reqReady[w_grantIdx] = 1'b1;
  end

`ifdef RECIP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wdCount;
  logic          r_rspErr;
  logic          r_fault;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= IW'(N - 1);
      r_grant      <= '0;
      r_recipX     <= '0;
      r_rspData    <= '0;
      r_rspValid   <= '0;
      r_rspInvalid <= 1'b0;
      r_busy       <= 1'b0;
      r_start      <= 1'b0;
`ifdef RECIP_ARB_TIMEOUT_EN
      r_wdCount    <= '0;
      r_rspErr     <= 1'b0;
      r_fault      <= 1'b0;
`endif
    end else begin
      r_start    <= 1'b0;
      r_rspValid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_recipX <= w_operand;
            r_grant  <= w_grantIdx;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef RECIP_ARB_TIMEOUT_EN
          r_wdCount <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (recip_done) begin
            r_rspData           <= recip_y;
            r_rspInvalid        <= recip_invalid;
            r_rspValid[r_grant] <= 1'b1;
`ifdef RECIP_ARB_TIMEOUT_EN
            r_rspErr            <= 1'b0;
`endif
            r_state             <= S_RESP;
          end
`ifdef RECIP_ARB_TIMEOUT_EN
          // A done arriving on the final counted cycle still takes priority.
          else if (r_wdCount == CW'(TIMEOUT - 1)) begin
            r_rspData           <= '0;
            r_rspInvalid        <= 1'b0;
            r_rspErr            <= 1'b1;
            r_fault             <= 1'b1;
            r_rspValid[r_grant] <= 1'b1;
            r_state             <= S_RESP;
          end else begin
            r_wdCount <= r_wdCount + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_last  <= r_grant;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = w_reqReady;
  assign rsp_valid   = r_rspValid;
  assign rsp_data    = r_rspData;
  assign rsp_invalid = r_rspInvalid;
  assign busy        = r_busy;
  assign recip_start = r_start;
  assign recip_x     = r_recipX;
`ifdef RECIP_ARB_TIMEOUT_EN
  assign rsp_err     = r_rspErr;
  assign fault       = r_fault;
`else
  assign rsp_err     = 1'b0;
  assign fault       = 1'b0;
`endif

endmodule
